// File: rtl/svc_rv_fetch_ctrl.sv
// svc_rv_fetch_ctrl
// Instruction-fetch sequencer for the RV core. Owns the program counter,
// keeps at most one instruction-memory request in flight, hands fetched
// words to decode together with their PC, honours decode back-pressure and
// throws away in-flight fetches that belong to a path abandoned by a redirect.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   imem_req_o      fetch request valid (forced low while rst_i is high)
//   imem_addr_o     fetch address, word aligned (current pc)
//   imem_ready_i    memory accepts the request this cycle
//   imem_rvalid_i   response valid
//   imem_rdata_i    fetched instruction word
//   id_stall_i      decode cannot accept this cycle
//   redirect_i      control-flow change (branch/jump/trap)
//   redirect_pc_i   new PC, low two bits ignored
//   pc_if_o         PC of the instruction delivered this cycle
//   pc_plus4_if_o   pc_if_o + 4 (wraps)
//   if_id_stall_o   IF/ID hold, copy of id_stall_i
//   if_id_flush_o   IF/ID flush, copy of redirect_i
//   instr_id_o      registered instruction for decode
//   valid_id_o      instr_id_o holds a real instruction
module svc_rv_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            id_stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_if_o,
  output logic [XLEN-1:0] pc_plus4_if_o,
  output logic            if_id_stall_o,
  output logic            if_id_flush_o,
  output logic [31:0]     instr_id_o,
  output logic            valid_id_o
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pcReq_q;
  logic [31:0]     holdInstr_q;
  logic [31:0]     instrId_q;
  logic            validId_q;

  logic            deliver;
  logic [31:0]     deliverInstr;
  logic [XLEN-1:0] redirectPcAligned;

  // Redirect targets are forced onto a word boundary; masking keeps every
  // bit of the input in use rather than slicing the low bits away.
  assign redirectPcAligned = redirect_pc_i & ~(XLEN'(3));

  // A delivery is either a fresh response that decode can take right now, or
  // the buffered word being released once the stall drops. Redirect overrides
  // both inside the sequential block.
  always_comb begin
    deliver      = 1'b0;
    deliverInstr = imem_rdata_i;
    if (state_q == S_WAIT && imem_rvalid_i && !id_stall_i) begin
      deliver = 1'b1;
    end else if (state_q == S_HOLD && !id_stall_i) begin
      deliver      = 1'b1;
      deliverInstr = holdInstr_q;
    end
  end

  // Sequencer: reset, then redirect, then normal ISSUE/WAIT/HOLD/DRAIN flow.
  // During a redirect the request already on the bus still shows the old pc;
  // if memory takes it, the response is stale and DRAIN swallows it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_ISSUE;
      pc_q        <= RESET_PC;
      pcReq_q     <= RESET_PC;
      holdInstr_q <= '0;
      instrId_q   <= '0;
      validId_q   <= 1'b0;
    end else if (redirect_i) begin
      pc_q        <= redirectPcAligned;
      validId_q   <= 1'b0;
      holdInstr_q <= '0;
      case (state_q)
        S_ISSUE:         state_q <= imem_ready_i ? S_DRAIN : S_ISSUE;
        S_WAIT, S_DRAIN: state_q <= imem_rvalid_i ? S_ISSUE : S_DRAIN;
        default:         state_q <= S_ISSUE;
      endcase
    end else begin
      case (state_q)
        S_ISSUE: begin
          if (imem_ready_i) begin
            pcReq_q <= pc_q;
            pc_q    <= pc_q + PC_STEP;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (id_stall_i) begin
              holdInstr_q <= imem_rdata_i;
              state_q     <= S_HOLD;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall_i) begin
            holdInstr_q <= '0;
            state_q     <= S_ISSUE;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid_i) begin
            state_q <= S_ISSUE;
          end
        end
        default: state_q <= S_ISSUE;
      endcase

      // Decode-facing register: load on delivery, bubble when decode is free
      // but nothing arrived, otherwise hold for the stalled decode stage.
      if (deliver) begin
        instrId_q <= deliverInstr;
        validId_q <= 1'b1;
      end else if (!id_stall_i) begin
        validId_q <= 1'b0;
      end
    end
  end

  assign imem_req_o    = (state_q == S_ISSUE) && !rst_i;
  assign imem_addr_o   = pc_q;
  // pcReq_q names the word being delivered in WAIT or HOLD, so the IF/ID
  // register latches the matching PC on the same edge as the instruction.
  assign pc_if_o       = pcReq_q;
  assign pc_plus4_if_o = pcReq_q + PC_STEP;
  assign if_id_stall_o = id_stall_i;
  assign if_id_flush_o = redirect_i;
  assign instr_id_o    = instrId_q;
  assign valid_id_o    = validId_q;

endmodule

// File: tb/tb_svc_rv_fetch_ctrl.sv
// tb_svc_rv_fetch_ctrl
// Drives svc_rv_fetch_ctrl one cycle at a time: directed scenarios followed
// by randomized traffic from a one-outstanding memory, with every cycle's
// outputs compared against a transaction-level reference model.
module tb_svc_rv_fetch_ctrl;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        idStall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] pcIf;
  logic [31:0] pcPlus4If;
  logic        ifIdStall;
  logic        ifIdFlush;
  logic [31:0] instrId;
  logic        validId;

  int total = 0;
  int bad   = 0;

  // Reference model: next fetch address, whether a request is in flight
  // (and whether it is from an abandoned path), an optional buffered word,
  // and what decode currently sees.
  logic [31:0] mPc;
  logic [31:0] mOutAddr;
  logic [31:0] mHeldInstr;
  logic [31:0] mHeldAddr;
  logic [31:0] mInstr;
  bit          mOutstanding;
  bit          mStale;
  bit          mHeld;
  bit          mValid;

  // Randomized memory: one pending request with a random response delay.
  bit          memPending;
  logic [31:0] memAddr;
  int          memDelay;

  always #5 clk = ~clk;

  svc_rv_fetch_ctrl #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imemReq),
    .imem_addr_o   (imemAddr),
    .imem_ready_i  (imemReady),
    .imem_rvalid_i (imemRvalid),
    .imem_rdata_i  (imemRdata),
    .id_stall_i    (idStall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .pc_if_o       (pcIf),
    .pc_plus4_if_o (pcPlus4If),
    .if_id_stall_o (ifIdStall),
    .if_id_flush_o (ifIdFlush),
    .instr_id_o    (instrId),
    .valid_id_o    (validId)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare this cycle's outputs (inputs already applied) with the model.
  task automatic checkCycle();
    bit          expReq;
    bit          dlv;
    logic [31:0] dAddr;
    expReq = !rst && !mOutstanding && !mHeld;
    checkOutput("imem_req", {31'b0, imemReq}, {31'b0, expReq});
    if (expReq) checkOutput("imem_addr", imemAddr, mPc);
    checkOutput("valid_id", {31'b0, validId}, {31'b0, mValid});
    if (mValid) checkOutput("instr_id", instrId, mInstr);
    checkOutput("if_id_stall", {31'b0, ifIdStall}, {31'b0, idStall});
    checkOutput("if_id_flush", {31'b0, ifIdFlush}, {31'b0, redirect});
    dlv   = 1'b0;
    dAddr = '0;
    if (!rst && !redirect && !idStall) begin
      if (mOutstanding && !mStale && imemRvalid) begin
        dlv   = 1'b1;
        dAddr = mOutAddr;
      end else if (mHeld) begin
        dlv   = 1'b1;
        dAddr = mHeldAddr;
      end
    end
    if (dlv) begin
      checkOutput("pc_if", pcIf, dAddr);
      checkOutput("pc_plus4_if", pcPlus4If, dAddr + 32'd4);
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic modelStep();
    bit          accept;
    bit          resp;
    bit          dlv;
    logic [31:0] dInstr;
    if (rst) begin
      mPc          = RESET_PC;
      mOutstanding = 1'b0;
      mStale       = 1'b0;
      mHeld        = 1'b0;
      mValid       = 1'b0;
      return;
    end
    accept = !mOutstanding && !mHeld && imemReady;
    resp   = mOutstanding && imemRvalid;
    if (redirect) begin
      mValid = 1'b0;
      mHeld  = 1'b0;
      if (accept || (mOutstanding && !resp)) begin
        mOutstanding = 1'b1;
        mStale       = 1'b1;
      end else begin
        mOutstanding = 1'b0;
        mStale       = 1'b0;
      end
      mPc = redirectPc & 32'hFFFF_FFFC;
      return;
    end
    dlv    = 1'b0;
    dInstr = '0;
    if (accept) begin
      mOutstanding = 1'b1;
      mStale       = 1'b0;
      mOutAddr     = mPc;
      mPc          = mPc + 32'd4;
    end else if (resp) begin
      mOutstanding = 1'b0;
      if (!mStale) begin
        if (!idStall) begin
          dlv    = 1'b1;
          dInstr = imemRdata;
        end else begin
          mHeld      = 1'b1;
          mHeldInstr = imemRdata;
          mHeldAddr  = mOutAddr;
        end
      end
      mStale = 1'b0;
    end else if (mHeld && !idStall) begin
      dlv    = 1'b1;
      dInstr = mHeldInstr;
      mHeld  = 1'b0;
    end
    if (dlv) begin
      mValid = 1'b1;
      mInstr = dInstr;
    end else if (!idStall) begin
      mValid = 1'b0;
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, update the model.
  task automatic applyStimulus(input bit r, input bit rdy, input bit rv,
                               input logic [31:0] rd, input bit st,
                               input bit rdr, input logic [31:0] rpc);
    @(negedge clk);
    rst        = r;
    imemReady  = rdy;
    imemRvalid = rv;
    imemRdata  = rd;
    idStall    = st;
    redirect   = rdr;
    redirectPc = rpc;
    #1;
    checkCycle();
    modelStep();
  endtask

  initial begin
    rst        = 1'b1;
    imemReady  = 1'b0;
    imemRvalid = 1'b0;
    imemRdata  = '0;
    idStall    = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    repeat (2) @(posedge clk);
    mPc          = RESET_PC;
    mOutAddr     = '0;
    mHeldInstr   = '0;
    mHeldAddr    = '0;
    mInstr       = '0;
    mOutstanding = 1'b0;
    mStale       = 1'b0;
    mHeld        = 1'b0;
    mValid       = 1'b0;
    memPending   = 1'b0;
    memAddr      = '0;
    memDelay     = 0;

    // Reset holds the request low.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Back-to-back fetches from RESET_PC, then a 3-cycle stall over 0x104.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("first_addr", imemAddr, 32'h100);
    applyStimulus(0, 0, 1, memWord(32'h100), 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("second_addr", imemAddr, 32'h104);
    applyStimulus(0, 0, 1, memWord(32'h104), 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("held_pc_if", pcIf, 32'h104);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("held_instr", instrId, memWord(32'h104));
    applyStimulus(0, 0, 1, memWord(32'h108), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Redirect to 0x200 while waiting; stale response two cycles later.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, memWord(32'h10C), 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("redir_addr", imemAddr, 32'h200);
    applyStimulus(0, 0, 1, memWord(32'h200), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Redirect on an accepted request, then a second redirect while draining.
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h300);
    checkOutput("old_addr_on_redir", imemAddr, 32'h204);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h400);
    applyStimulus(0, 0, 1, memWord(32'h204), 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("drain_redir_addr", imemAddr, 32'h400);
    applyStimulus(0, 0, 1, memWord(32'h400), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Redirect with decode stalled and the hold buffer full; unaligned target.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, memWord(32'h404), 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h203);
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    checkOutput("stall_redir_valid", {31'b0, validId}, 32'h0);
    checkOutput("aligned_addr", imemAddr, 32'h200);
    applyStimulus(0, 0, 1, memWord(32'h200), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space.
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, memWord(32'hFFFF_FFFC), 0, 0, 0);
    checkOutput("wrap_plus4", pcPlus4If, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("wrap_addr", imemAddr, 32'h0);
    applyStimulus(0, 0, 1, memWord(32'h0), 0, 0, 0);

    // Reset mid-fetch: late response ignored, restart at RESET_PC.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, memWord(32'h4), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("late_rsp_valid", {31'b0, validId}, 32'h0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("restart_addr", imemAddr, RESET_PC);
    applyStimulus(0, 0, 1, memWord(RESET_PC), 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          r;
      bit          rdy;
      bit          rv;
      bit          st;
      bit          rdr;
      bit          acc;
      logic [31:0] rd;
      logic [31:0] rpc;
      logic [31:0] accAddr;
      r   = ($urandom_range(249, 0) == 0);
      rdy = ($urandom_range(2, 0) != 0);
      st  = ($urandom_range(2, 0) == 0);
      rdr = ($urandom_range(11, 0) == 0);
      rpc = $urandom;
      if (memPending && memDelay == 0) begin
        rv = 1'b1;
        rd = memWord(memAddr);
      end else if (!memPending && $urandom_range(19, 0) == 0) begin
        rv = 1'b1;
        rd = $urandom;
      end else begin
        rv = 1'b0;
        rd = $urandom;
      end
      acc     = !r && !mOutstanding && !mHeld && rdy;
      accAddr = mPc;
      applyStimulus(r, rdy, rv, rd, st, rdr, rpc);
      if (r) memPending = 1'b0;
      else if (memPending && memDelay == 0) memPending = 1'b0;
      else if (memPending) memDelay--;
      if (acc) begin
        memPending = 1'b1;
        memAddr    = accAddr;
        memDelay   = $urandom_range(3, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/svc_rv_fetch_ctrl.md
# svc_rv_fetch_ctrl

Instruction-fetch sequencer for the RV core. It owns the program counter and issues requests to the instruction memory port with at most one request outstanding. It hands each fetched instruction to decode together with the PC values that the IF→ID pipeline register captures. It applies decode back-pressure and control-flow redirects, discarding any in-flight fetch from the wrong path.

## Interface
Parameters:
- `XLEN`, 32, address/data width
- `RESET_PC`, 0, PC loaded by reset; bits [1:0] must be 0

Ports:
- `clk` input 1 — clock
- `rst` input 1 — reset, synchronous, active-high
- `imem_req` output 1 — fetch request valid
- `imem_addr` output XLEN — fetch address, word aligned
- `imem_ready` input 1 — memory accepts request this cycle (req && ready)
- `imem_rvalid` input 1 — response valid
- `imem_rdata` input 32 — fetched instruction
- `id_stall` input 1 — decode cannot accept this cycle
- `redirect` input 1 — control-flow change (branch/jump/trap)
- `redirect_pc` input XLEN — new PC; bits [1:0] ignored, treated as 0
- `pc_if` output XLEN — PC of the instruction delivered this cycle, to the IF/ID register
- `pc_plus4_if` output XLEN — `pc_if` + 4, mod 2^XLEN
- `if_id_stall` output 1 — IF/ID register hold; equals `id_stall`
- `if_id_flush` output 1 — IF/ID register flush; equals `redirect`
- `instr_id` output 32 — registered instruction for decode
- `valid_id` output 1 — `instr_id` holds a real instruction

## Operation
- Registers:
  - `pc`: next fetch address
  - `pc_req`: address of the outstanding or held fetch
  - state
  - hold buffer `hold_instr`
- States:
  - ISSUE: `imem_req`=1, `imem_addr`=`pc`.
    - On `imem_ready`: `pc_req`←`pc`, `pc`←`pc`+4, go to WAIT.
  - WAIT: request outstanding, `imem_req`=0.
    - `imem_rvalid` && !`id_stall`: deliver `imem_rdata`, go to ISSUE.
    - `imem_rvalid` && `id_stall`: capture into `hold_instr`, go to HOLD.
  - HOLD: response buffered, no request issued.
    - When !`id_stall`: deliver `hold_instr`, go to ISSUE.
  - DRAIN: a stale request is outstanding.
    - `imem_rvalid`: discard the response, go to ISSUE.
- Deliver means:
  - `instr_id`←instruction and `valid_id`←1 at the clock edge.
  - `pc_if`=`pc_req` in the same cycle, so the IF/ID register latches the matching PC.
- Any cycle with !`id_stall` and no delivery: `valid_id`←0 (bubble). `pc_if` is don't-care.
- `id_stall`=1 without `redirect`: `instr_id` and `valid_id` hold.
- `redirect` has priority over everything, including `id_stall`:
  - `pc`←`redirect_pc`; `valid_id`←0; hold buffer cleared.
  - Next state:
    - ISSUE with `imem_ready` this cycle (stale request accepted) → DRAIN.
    - ISSUE without `imem_ready` → ISSUE.
    - WAIT with no `imem_rvalid` this cycle → DRAIN.
    - WAIT with `imem_rvalid` this cycle → response discarded, ISSUE.
    - HOLD → ISSUE.
    - DRAIN with no `imem_rvalid` → DRAIN, with `pc` updated.
    - DRAIN with `imem_rvalid` → ISSUE.
  - During `redirect`, `imem_addr` still shows the old `pc`. Acceptance of that request is handled by the DRAIN rule above.
- Arithmetic: all PC math is XLEN-bit and wraps, e.g. 0xFFFFFFFC+4 = 0.
- A response arriving in ISSUE (none outstanding) is a protocol error. It is ignored.

## Timing
- Reset (`rst`=1 at an edge):
  - state=ISSUE, `pc`=`RESET_PC`, `valid_id`=0, hold cleared.
  - `imem_req` is forced to 0 while `rst`=1. It is first 1 in the first cycle with `rst`=0.
  - Reset mid-fetch abandons the outstanding request. The first response after reset in ISSUE is ignored.
- Latency:
  - Request accepted at cycle t, `imem_rvalid` at t+k (k≥1) → `valid_id`=1 at t+k+1.
  - Next request issued at t+k+1.
- Throughput: one instruction per 2 cycles at best (k=1).
- Redirect at cycle t: `valid_id`=0 at t+1.
  - Not draining: first request to `redirect_pc` at t+1.
  - Draining: request follows the stale `imem_rvalid` by one cycle.
- `if_id_stall` and `if_id_flush` are combinational pass-throughs with zero latency.

## Test plan
- Reset, `RESET_PC`=0x100, memory with k=1 always ready → requests at 0x100, 0x104, 0x108; `valid_id` on alternate cycles; `pc_if` 0x100/`pc_plus4_if` 0x104 latched with the first instruction.
- `id_stall` held 3 cycles across an `imem_rvalid` for 0x104 → HOLD, no `imem_req`; after release `instr_id` is the 0x104 word and `pc_if`=0x104; no instruction lost or duplicated.
- `redirect` to 0x200 in WAIT, response 2 cycles later → stale word never reaches `valid_id`; next `imem_addr`=0x200 the cycle after the stale `imem_rvalid`.
- `redirect` to 0x300 coincident with `imem_ready` in ISSUE, then second `redirect` to 0x400 in DRAIN → one discard; next fetch 0x400.
- `redirect` while `id_stall`=1 and HOLD full → `valid_id`=0 next cycle, hold dropped, fetch 0x... resumes at `redirect_pc`; `redirect_pc`=0x203 fetches 0x200.
- `RESET_PC`=0xFFFFFFFC → second fetch address 0x00000000; `rst` asserted while WAIT → `valid_id`=0, restart at `RESET_PC`, late response ignored.
